// File: rtl/accel_job_sched_if.sv
// Requester/accelerator bundle for accel_job_sched.
// Signal suffixes give the direction as seen by the scheduler.
interface accel_job_sched_if #(
    parameter int NumReq  = 2,
    parameter int OpWidth = 8
);
    localparam int OwW = $clog2(NumReq);

    logic [NumReq-1:0]              req_valid_i;
    logic [NumReq-1:0][OpWidth-1:0] req_op_i;
    logic [NumReq-1:0]              req_ready_o;
    logic                           accel_start_o;
    logic [OpWidth-1:0]             accel_op_o;
    logic                           accel_abort_o;
    logic                           accel_done_i;
    logic [NumReq-1:0]              rsp_valid_o;
    logic                           rsp_err_o;
    logic [NumReq-1:0]              rsp_ready_i;
    logic                           busy_o;
    logic [OwW-1:0]                 owner_o;

    modport master (
        output req_valid_i, req_op_i, accel_done_i, rsp_ready_i,
        input  req_ready_o, accel_start_o, accel_op_o, accel_abort_o,
        input  rsp_valid_o, rsp_err_o, busy_o, owner_o
    );

    modport slave (
        input  req_valid_i, req_op_i, accel_done_i, rsp_ready_i,
        output req_ready_o, accel_start_o, accel_op_o, accel_abort_o,
        output rsp_valid_o, rsp_err_o, busy_o, owner_o
    );
endinterface

// File: rtl/accel_job_sched.sv
// Round-robin job scheduler sharing one accelerator among NumReq requesters.
// Timeout/abort path is built only when ACCEL_JOB_SCHED_TIMEOUT_EN is defined.
module accel_job_sched #(
    parameter int NumReq        = 2,
    parameter int OpWidth       = 8,
    parameter int TimeoutCycles = 1024
) (
    input logic              clk_i,
    input logic              rst_i,
    accel_job_sched_if.slave bus
);
    localparam int OwW = $clog2(NumReq);
    localparam logic [NumReq-1:0] One = NumReq'(1);

    if (NumReq < 2) begin : g_chk_req
        $error("NumReq must be at least 2");
    end
    if (TimeoutCycles < 2) begin : g_chk_tmo
        $error("TimeoutCycles must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;

    state_e             state;
    logic [OwW-1:0]     last_grant;
    logic [OwW-1:0]     owner;
    logic [OwW-1:0]     win;
    logic               any;
    logic [OpWidth-1:0] op_q;
    logic               start_q;
    logic               busy_q;
    logic [NumReq-1:0]  rsp_q;
    logic               tmo;

    // Search starts just past the last completed owner and wraps.
    always_comb begin
        int idx;
        idx = 0;
        any = 1'b0;
        win = '0;
        for (int k = 1; k <= NumReq; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!any && bus.req_valid_i[OwW'(idx)]) begin
                any = 1'b1;
                win = OwW'(idx);
            end
        end
    end

    always_comb begin
        bus.req_ready_o = '0;
        if (state == IDLE && any && !rst_i) bus.req_ready_o[win] = 1'b1;
    end

`ifdef ACCEL_JOB_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam logic [TW-1:0] TLast = TW'(TimeoutCycles - 1);
    localparam logic [TW-1:0] TMax  = TW'(TimeoutCycles);

    logic [TW-1:0] timer;
    logic          err_q;

    // A done arriving on the last cycle still wins over the abort.
    assign tmo = state == WAIT && timer == TLast && !bus.accel_done_i;
    assign bus.accel_abort_o = tmo && !rst_i;
    assign bus.rsp_err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer <= '0;
        end else if (state == START) begin
            timer <= '0;
        end else if (state == WAIT && timer != TMax) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (state == WAIT) begin
            err_q <= tmo;
        end else if (state == RESP && bus.rsp_ready_i[owner]) begin
            err_q <= 1'b0;
        end
    end
`else
    assign tmo = 1'b0;
    assign bus.accel_abort_o = 1'b0;
    assign bus.rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= OwW'(NumReq - 1);
            owner      <= '0;
            op_q       <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            rsp_q      <= '0;
        end else begin
            start_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        owner   <= win;
                        op_q    <= bus.req_op_i[win];
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.accel_done_i || tmo) begin
                        rsp_q <= One << owner;
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i[owner]) begin
                        rsp_q      <= '0;
                        last_grant <= owner;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.accel_start_o = start_q;
    assign bus.accel_op_o    = op_q;
    assign bus.rsp_valid_o   = rsp_q;
    assign bus.busy_o        = busy_q;
    assign bus.owner_o       = owner;
endmodule

// File: tb/tb_accel_job_sched.sv
// Scoreboard bench for accel_job_sched: directed jobs push expected responses,
// a monitor pops them on every response handshake.
module tb_accel_job_sched;
    localparam int NR = 2;
    localparam int OW = 8;
    localparam int TC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    accel_job_sched_if #(.NumReq(NR), .OpWidth(OW)) bus ();

    accel_job_sched #(
        .NumReq(NR),
        .OpWidth(OW),
        .TimeoutCycles(TC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [NR-1:0] vec;
        logic          err;
        logic [OW-1:0] op;
    } exp_t;

    exp_t sbq[$];
    int tests = 0;
    int fails = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(logic [NR-1:0] v, logic e, logic [OW-1:0] o);
        exp_t x;
        x.vec = v;
        x.err = e;
        x.op  = o;
        sbq.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.rsp_valid_o & bus.rsp_ready_i) != '0) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: rsp_valid=%b with no job outstanding",
                         bus.rsp_valid_o);
            end else begin
                e = sbq.pop_front();
                check("sb_owner", 32'(bus.rsp_valid_o), 32'(e.vec));
                check("sb_err", 32'(bus.rsp_err_o), 32'(e.err));
                check("sb_op", 32'(bus.accel_op_o), 32'(e.op));
            end
        end
    end

    // Caller is in an IDLE cycle with requests already driven.
    task automatic job_fast(int w, logic [OW-1:0] op);
        logic [NR-1:0] v;
        v = NR'(1) << w;
        smp();
        check("rr_grant", 32'(bus.req_ready_o), 32'(v));
        push(v, 1'b0, op);
        cyc();
        smp();
        check("rr_owner", 32'(bus.owner_o), 32'(w));
        check("rr_start", 32'(bus.accel_start_o), 32'd1);
        cyc();
        bus.accel_done_i = 1'b1;
        cyc();
        bus.accel_done_i = 1'b0;
        bus.rsp_ready_i = '1;
        smp();
        check("rr_rsp", 32'(bus.rsp_valid_o), 32'(v));
        cyc();
        bus.rsp_ready_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_abort;
        int n_rsp;
        bus.req_valid_i  = '0;
        bus.req_op_i     = '0;
        bus.accel_done_i = 1'b0;
        bus.rsp_ready_i  = '0;
        rst = 1'b1;
        cyc();
        bus.req_valid_i = '1;
        smp();
        check("rst_ready", 32'(bus.req_ready_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_start", 32'(bus.accel_start_o), 32'd0);
        check("rst_rsp", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_op", 32'(bus.accel_op_o), 32'd0);
        check("rst_owner", 32'(bus.owner_o), 32'd0);
        check("rst_err", 32'(bus.rsp_err_o), 32'd0);
        check("rst_abort", 32'(bus.accel_abort_o), 32'd0);

        // single job: accept cycle 0, done cycle 5, response cycle 6
        cyc();
        rst = 1'b0;
        bus.req_valid_i = 2'b01;
        bus.req_op_i[0] = 8'h3C;
        smp();
        check("t1_ready", 32'(bus.req_ready_o), 32'h1);
        push(2'b01, 1'b0, 8'h3C);
        cyc();
        bus.req_valid_i = '0;
        smp();
        check("t1_start", 32'(bus.accel_start_o), 32'd1);
        check("t1_op", 32'(bus.accel_op_o), 32'h3C);
        check("t1_busy", 32'(bus.busy_o), 32'd1);
        cyc();
        smp();
        check("t1_start_pulse", 32'(bus.accel_start_o), 32'd0);
        cyc();
        cyc();
        cyc();
        bus.accel_done_i = 1'b1;
        smp();
        check("t1_rsp_early", 32'(bus.rsp_valid_o), 32'd0);
        cyc();
        bus.accel_done_i = 1'b0;
        bus.rsp_ready_i = 2'b01;
        smp();
        check("t1_rsp", 32'(bus.rsp_valid_o), 32'h1);
        check("t1_err", 32'(bus.rsp_err_o), 32'd0);
        cyc();
        bus.rsp_ready_i = '0;
        smp();
        check("t1_idle", 32'(bus.busy_o), 32'd0);
        check("t1_rsp_drop", 32'(bus.rsp_valid_o), 32'd0);

        // round-robin from reset: 0,1,0,1
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req_valid_i = 2'b11;
        bus.req_op_i[0] = 8'hA1;
        bus.req_op_i[1] = 8'hB2;
        job_fast(0, 8'hA1);
        job_fast(1, 8'hB2);
        job_fast(0, 8'hA1);
        job_fast(1, 8'hB2);
        bus.req_valid_i = '0;

        // spurious done in IDLE, then back-pressure with done in RESP
        cyc();
        bus.accel_done_i = 1'b1;
        smp();
        cyc();
        bus.accel_done_i = 1'b0;
        smp();
        check("sp_idle_busy", 32'(bus.busy_o), 32'd0);
        cyc();
        bus.req_valid_i = 2'b10;
        bus.req_op_i[1] = 8'h5A;
        smp();
        check("bp_grant", 32'(bus.req_ready_o), 32'h2);
        push(2'b10, 1'b0, 8'h5A);
        cyc();
        bus.req_valid_i = 2'b11;
        cyc();
        bus.accel_done_i = 1'b1;
        cyc();
        bus.accel_done_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.accel_done_i = (i == 2);
            bus.rsp_ready_i = 2'b01;
            smp();
            check("bp_hold", 32'(bus.rsp_valid_o), 32'h2);
            check("bp_nogrant", 32'(bus.req_ready_o), 32'd0);
            cyc();
        end
        bus.accel_done_i = 1'b0;
        bus.rsp_ready_i = 2'b10;
        smp();
        check("bp_release", 32'(bus.rsp_valid_o), 32'h2);
        cyc();
        bus.rsp_ready_i = '0;
        job_fast(0, 8'hA1);
        bus.req_valid_i = '0;

`ifdef ACCEL_JOB_SCHED_TIMEOUT_EN
        // timeout: start T+1, abort T+9, error response T+10
        cyc();
        bus.req_valid_i = 2'b10;
        bus.req_op_i[1] = 8'h77;
        smp();
        check("to_grant", 32'(bus.req_ready_o), 32'h2);
        push(2'b10, 1'b1, 8'h77);
        cyc();
        bus.req_valid_i = '0;
        n_abort = 0;
        for (int i = 2; i <= 8; i++) begin
            cyc();
            smp();
            if (bus.accel_abort_o) n_abort++;
        end
        check("to_no_early_abort", 32'(n_abort), 32'd0);
        cyc();
        smp();
        check("to_abort", 32'(bus.accel_abort_o), 32'd1);
        check("to_rsp_not_yet", 32'(bus.rsp_valid_o), 32'd0);
        cyc();
        bus.rsp_ready_i = 2'b10;
        smp();
        check("to_rsp", 32'(bus.rsp_valid_o), 32'h2);
        check("to_err", 32'(bus.rsp_err_o), 32'd1);
        check("to_abort_pulse", 32'(bus.accel_abort_o), 32'd0);
        cyc();
        bus.rsp_ready_i = '0;
        smp();
        check("to_idle", 32'(bus.busy_o), 32'd0);

        // done on the timer's last cycle wins
        cyc();
        bus.req_valid_i = 2'b01;
        smp();
        push(2'b01, 1'b0, 8'hA1);
        cyc();
        bus.req_valid_i = '0;
        for (int i = 2; i <= 8; i++) cyc();
        cyc();
        bus.accel_done_i = 1'b1;
        smp();
        check("col_no_abort", 32'(bus.accel_abort_o), 32'd0);
        cyc();
        bus.accel_done_i = 1'b0;
        bus.rsp_ready_i = 2'b01;
        smp();
        check("col_rsp", 32'(bus.rsp_valid_o), 32'h1);
        check("col_err", 32'(bus.rsp_err_o), 32'd0);
        cyc();
        bus.rsp_ready_i = '0;
`else
        // no timer: WAIT holds for 100 cycles without abort
        cyc();
        bus.req_valid_i = 2'b10;
        smp();
        check("nt_grant", 32'(bus.req_ready_o), 32'h2);
        push(2'b10, 1'b0, 8'h5A);
        cyc();
        bus.req_valid_i = '0;
        n_abort = 0;
        n_rsp = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            smp();
            if (bus.accel_abort_o) n_abort++;
            if (bus.rsp_valid_o != '0) n_rsp++;
        end
        check("nt_abort", 32'(n_abort), 32'd0);
        check("nt_rsp", 32'(n_rsp), 32'd0);
        check("nt_busy", 32'(bus.busy_o), 32'd1);
        cyc();
        bus.accel_done_i = 1'b1;
        cyc();
        bus.accel_done_i = 1'b0;
        bus.rsp_ready_i = 2'b10;
        smp();
        check("nt_rsp_final", 32'(bus.rsp_valid_o), 32'h2);
        check("nt_err", 32'(bus.rsp_err_o), 32'd0);
        cyc();
        bus.rsp_ready_i = '0;
`endif

        // reset during WAIT drops the job and restores priority to 0
        cyc();
        bus.req_valid_i = 2'b10;
        bus.req_op_i[1] = 8'hC3;
        smp();
        check("rw_grant", 32'(bus.req_ready_o), 32'h2);
        cyc();
        bus.req_valid_i = '0;
        cyc();
        cyc();
        rst = 1'b1;
        smp();
        cyc();
        rst = 1'b0;
        smp();
        check("rw_busy", 32'(bus.busy_o), 32'd0);
        check("rw_start", 32'(bus.accel_start_o), 32'd0);
        check("rw_op", 32'(bus.accel_op_o), 32'd0);
        check("rw_owner", 32'(bus.owner_o), 32'd0);
        check("rw_rsp", 32'(bus.rsp_valid_o), 32'd0);
        check("rw_err", 32'(bus.rsp_err_o), 32'd0);
        check("rw_abort", 32'(bus.accel_abort_o), 32'd0);
        cyc();
        bus.accel_done_i = 1'b1;
        cyc();
        bus.accel_done_i = 1'b0;
        bus.req_valid_i = 2'b11;
        job_fast(0, 8'hA1);
        bus.req_valid_i = '0;

        cyc();
        cyc();
        check("sb_drain", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
